// File: rtl/cdn_message_bus_mac_ctrl.sv
// cdn_message_bus_mac_ctrl
// MAC-side PIPE message bus controller. Two local requesters (0: link /
// equalization sequencer, 1: register configuration path) are arbitrated
// round-robin onto the 8-bit m2p message bus. Each command is serialized
// into bus bytes. The p2m bus is decoded for write_ack and read_completion,
// and one response is returned per committed write or read. A missing PHY
// answer produces a timeout error response.
//
// Ports
//   pclk            PIPE clock, all logic on the rising edge
//   reset           asynchronous active-low reset
//   req_valid[i]    requester i has a pending request (held until req_ready)
//   req_cmd[i]      01 write_uncommitted, 10 write_committed, 11 read, 00 illegal
//   req_addr[i]     12-bit PHY register address
//   req_data[i]     write data (ignored for reads)
//   req_ready       one-hot accept pulse in the IDLE cycle of the grant
//   m2p_message_bus registered MAC-to-PHY byte stream
//   p2m_message_bus PHY-to-MAC byte stream
//   rsp_valid       one-cycle response pulse
//   rsp_id          requester the response belongs to
//   rsp_data        read data, 0 for write responses and timeouts
//   rsp_err         timeout flag, qualified by rsp_valid
//   busy            high whenever the controller is not IDLE
//   phy_req_seen    pulse when a PHY-initiated write/read frame starts on p2m
//   proto_err       pulse for an unexpected/unknown p2m frame or illegal req_cmd
module cdn_message_bus_mac_ctrl #(
   parameter int ACK_TIMEOUT = 64
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [1:0][1:0]  req_cmd,
   input  logic [1:0][11:0] req_addr,
   input  logic [1:0][7:0]  req_data,
   output logic [1:0]       req_ready,
   output logic [7:0]       m2p_message_bus,
   input  logic [7:0]       p2m_message_bus,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [7:0]       rsp_data,
   output logic             rsp_err,
   output logic             busy,
   output logic             phy_req_seen,
   output logic             proto_err
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(ACK_TIMEOUT - 1);

   localparam logic [1:0] CMD_ILLEGAL = 2'b00;
   localparam logic [1:0] CMD_WR_UNC  = 2'b01;
   localparam logic [1:0] CMD_RD      = 2'b11;
   localparam logic [3:0] P2M_RC      = 4'h4;
   localparam logic [3:0] P2M_ACK     = 4'h5;

   typedef enum logic [2:0] {IDLE, TX0, TX1, TX2, WAIT_ACK, WAIT_RC, RESP} state_t;

   state_t         state_q, state_d;
   logic [1:0]     cmd_q, cmd_d;
   logic [11:0]    addr_q, addr_d;
   logic [7:0]     data_q, data_d;
   logic           id_q, id_d;
   logic           lastGrant_q, lastGrant_d;
   logic           lock_q, lock_d;
   logic           lockOwner_q, lockOwner_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     rem_q, rem_d;
   logic           rcFrame_q, rcFrame_d;
   logic [7:0]     m2p_q, m2p_d;
   logic           rspValid_q, rspValid_d;
   logic           rspId_q, rspId_d;
   logic [7:0]     rspData_q, rspData_d;
   logic           rspErr_q, rspErr_d;
   logic           phyReq_q, phyReq_d;
   logic           proto_q;
   logic           ackEvt, rcEvt, decProto, reqProto;
   logic [1:0]     elig;
   logic           pick;

   // While locked only the lock owner may be granted. With both eligible the
   // requester that was not granted last wins; a single eligible one wins.
   always_comb begin
      elig = req_valid;
      if (lock_q) begin
         elig = req_valid & (lockOwner_q ? 2'b10 : 2'b01);
      end
      pick = (elig == 2'b11) ? ~lastGrant_q : elig[1];
   end

   // The p2m decoder tracks frame boundaries in every state so that payload
   // bytes of any frame are never mistaken for a new command nibble. A
   // read_completion only counts when its header was accepted in WAIT_RC.
   always_comb begin
      rem_d     = rem_q;
      rcFrame_d = rcFrame_q;
      ackEvt    = 1'b0;
      rcEvt     = 1'b0;
      decProto  = 1'b0;
      phyReq_d  = 1'b0;
      if (rem_q != 2'd0) begin
         rem_d = rem_q - 2'd1;
         if (rem_q == 2'd1) begin
            rcFrame_d = 1'b0;
            rcEvt     = rcFrame_q && (state_q == WAIT_RC);
         end
      end else begin
         case (p2m_message_bus[7:4])
            4'h0: begin
               rem_d = 2'd0;
            end
            4'h1, 4'h2: begin
               rem_d    = 2'd2;
               phyReq_d = 1'b1;
            end
            4'h3: begin
               rem_d    = 2'd1;
               phyReq_d = 1'b1;
            end
            P2M_RC: begin
               rem_d = 2'd1;
               if (state_q == WAIT_RC) begin
                  rcFrame_d = 1'b1;
               end else begin
                  decProto = 1'b1;
               end
            end
            P2M_ACK: begin
               if (state_q == WAIT_ACK) begin
                  ackEvt = 1'b1;
               end else begin
                  decProto = 1'b1;
               end
            end
            default: begin
               decProto = 1'b1;
            end
         endcase
      end
   end

   // Main sequencer: grant in IDLE, serialize the command, then wait for the
   // matching PHY event or the timeout. m2p_d is the byte shown next cycle, so
   // the header is prepared in the grant cycle itself.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      data_d      = data_q;
      id_d        = id_q;
      lastGrant_d = lastGrant_q;
      lock_d      = lock_q;
      lockOwner_d = lockOwner_q;
      cnt_d       = cnt_q;
      m2p_d       = 8'h00;
      rspValid_d  = 1'b0;
      rspId_d     = rspId_q;
      rspData_d   = rspData_q;
      rspErr_d    = rspErr_q;
      reqProto    = 1'b0;
      req_ready   = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (elig != 2'b00) begin
               req_ready   = pick ? 2'b10 : 2'b01;
               lastGrant_d = pick;
               if (req_cmd[pick] == CMD_ILLEGAL) begin
                  reqProto = 1'b1;
               end else begin
                  cmd_d   = req_cmd[pick];
                  addr_d  = req_addr[pick];
                  data_d  = req_data[pick];
                  id_d    = pick;
                  m2p_d   = {2'b00, req_cmd[pick], req_addr[pick][11:8]};
                  state_d = TX0;
                  if (req_cmd[pick] == CMD_WR_UNC) begin
                     lock_d      = 1'b1;
                     lockOwner_d = pick;
                  end
               end
            end
         end
         TX0: begin
            m2p_d   = addr_q[7:0];
            state_d = TX1;
         end
         TX1: begin
            if (cmd_q == CMD_RD) begin
               cnt_d   = '0;
               state_d = WAIT_RC;
            end else begin
               m2p_d   = data_q;
               state_d = TX2;
            end
         end
         TX2: begin
            if (cmd_q == CMD_WR_UNC) begin
               state_d = IDLE;
            end else begin
               cnt_d   = '0;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK, WAIT_RC: begin
            // A matching event in the last wait cycle beats the timeout.
            if (ackEvt || rcEvt || (cnt_q == LAST_WAIT)) begin
               rspValid_d = 1'b1;
               rspId_d    = id_q;
               rspErr_d   = !(ackEvt || rcEvt);
               rspData_d  = rcEvt ? p2m_message_bus : 8'h00;
               state_d    = RESP;
               if (state_q == WAIT_ACK) begin
                  lock_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // All state and outputs are registered; reset drops any transaction in
   // flight and makes requester 0 the first one granted.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cmd_q       <= 2'b00;
         addr_q      <= 12'h000;
         data_q      <= 8'h00;
         id_q        <= 1'b0;
         lastGrant_q <= 1'b1;
         lock_q      <= 1'b0;
         lockOwner_q <= 1'b0;
         cnt_q       <= '0;
         rem_q       <= 2'd0;
         rcFrame_q   <= 1'b0;
         m2p_q       <= 8'h00;
         rspValid_q  <= 1'b0;
         rspId_q     <= 1'b0;
         rspData_q   <= 8'h00;
         rspErr_q    <= 1'b0;
         phyReq_q    <= 1'b0;
         proto_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         id_q        <= id_d;
         lastGrant_q <= lastGrant_d;
         lock_q      <= lock_d;
         lockOwner_q <= lockOwner_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         rcFrame_q   <= rcFrame_d;
         m2p_q       <= m2p_d;
         rspValid_q  <= rspValid_d;
         rspId_q     <= rspId_d;
         rspData_q   <= rspData_d;
         rspErr_q    <= rspErr_d;
         phyReq_q    <= phyReq_d;
         proto_q     <= decProto | reqProto;
      end
   end

   assign m2p_message_bus = m2p_q;
   assign rsp_valid       = rspValid_q;
   assign rsp_id          = rspId_q;
   assign rsp_data        = rspData_q;
   assign rsp_err         = rspErr_q;
   assign busy            = (state_q != IDLE);
   assign phy_req_seen    = phyReq_q;
   assign proto_err       = proto_q;

endmodule
